// File: rtl/adc_frame_packer.sv
// ADC sample-pair frame packer feeding uart_tx via start_tx/tx_busy.
// Define ADC_FRAME_CHECKSUM_EN to append an XOR checksum byte (5-byte frame).
module adc_frame_packer #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] ch1,
  input  logic [11:0] ch2,
  input  logic        tx_busy,
  output logic [7:0]  data_to_tx,
  output logic        start_tx,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        tx_timeout
);

`ifdef ADC_FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t state, state_n;

  logic [11:0]   ch1_q, ch2_q;
  logic [2:0]    idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    byte_sel;
  logic          capture, idx_inc, done, tmo_hit;

  always_comb begin
    state_n = state;
    capture = 1'b0;
    idx_inc = 1'b0;
    done    = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_valid) begin
          capture = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD:  state_n = START;
      START: state_n = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) begin
          state_n = WAIT_LO;
        end else if (tmo_cnt == TO_MAX) begin
          // uart never acknowledged: count the byte as sent
          tmo_hit = 1'b1;
          state_n = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST) begin
            done = 1'b1;
            if (sample_valid) begin
              capture = 1'b1;
              state_n = LOAD;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_inc = 1'b1;
            state_n = LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = HEADER;
    case (idx)
      3'd0: byte_sel = HEADER;
      3'd1: byte_sel = ch1_q[11:4];
      3'd2: byte_sel = {ch1_q[3:0], ch2_q[11:8]};
      3'd3: byte_sel = ch2_q[7:0];
`ifdef ADC_FRAME_CHECKSUM_EN
      3'd4: byte_sel = HEADER ^ ch1_q[11:4]
                     ^ {ch1_q[3:0], ch2_q[11:8]}
                     ^ ch2_q[7:0];
`endif
      default: byte_sel = HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ch1_q      <= '0;
      ch2_q      <= '0;
      idx        <= '0;
      tmo_cnt    <= '0;
      data_to_tx <= '0;
      frame_busy <= 1'b0;
      overrun    <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        ch1_q <= ch1;
        ch2_q <= ch2;
        idx   <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (state == LOAD) begin
        data_to_tx <= byte_sel;
      end
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_HI && !tx_busy && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      frame_busy <= (state_n != IDLE);
      if (tmo_hit) begin
        tx_timeout <= 1'b1;
      end
      if (sample_valid && state != IDLE && !capture) begin
        overrun <= 1'b1;
      end
    end
  end

  assign start_tx   = (state == START);
  assign frame_done = done;

endmodule
